ctrl_pipeline: RTL and testbench

//  Carries main-decoder/ALU-decoder control bits from Decode through the ID/EX, EX/MEM and MEM/WB

---
 rtl/riscv_ctrl_pkg.sv | 53 +++++
 rtl/ctrl_stage_reg.sv | 22 ++
 rtl/ctrl_pipeline.sv | 166 ++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Control-path types shared by the RV32I pipeline control registers.
// ILLEGAL_OP_TRAP_EN enables the opcode legality check in ctrl_pipeline.
package riscv_ctrl_pkg;

    localparam int ALU_W = 3;
    localparam int RES_W = 2;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic [RES_W-1:0] result_src;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic             alu_src;
        logic [ALU_W-1:0] alu_control;
    } ctrl_e_t;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic [RES_W-1:0] result_src;
        logic             mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic [RES_W-1:0] result_src;
    } ctrl_w_t;

    localparam ctrl_e_t CTRL_E_BUBBLE = '0;
    localparam ctrl_m_t CTRL_M_BUBBLE = '0;
    localparam ctrl_w_t CTRL_W_BUBBLE = '0;

    function automatic logic op_legal(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_BEQ, OP_I, OP_JAL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline control register: async reset, hold enable,
// synchronous clear (clear only takes effect when enabled).
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= clr ? '0 : d;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM, MEM/WB control registers with stall/flush, PCSrcE and
// retire counter. Define ILLEGAL_OP_TRAP_EN to trap unlisted opcodes.
module ctrl_pipeline
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = ALU_W,
    parameter int RSRC_W    = RES_W,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ValidD,
    input  logic [6:0]           OpD,
    input  logic                 RegWriteD,
    input  logic [RSRC_W-1:0]    ResultSrcD,
    input  logic                 MemWriteD,
    input  logic                 JumpD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 FlushE,
    input  logic                 Stall,
    input  logic                 ZeroE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 ResultSrcE0,
    output logic                 RegWriteE,
    output logic                 PCSrcE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 RegWriteW,
    output logic [RSRC_W-1:0]    ResultSrcW,
    output logic [CNT_W-1:0]     RetiredCnt,
    output logic                 IllegalOp
);

    localparam int EW = $bits(ctrl_e_t);
    localparam int MW = $bits(ctrl_m_t);
    localparam int WW = $bits(ctrl_w_t);

    ctrl_e_t d_ctrl;
    ctrl_e_t e_ctrl;
    ctrl_m_t m_next;
    ctrl_m_t m_ctrl;
    ctrl_w_t w_next;
    ctrl_w_t w_ctrl;

    logic [EW-1:0] e_q;
    logic [MW-1:0] m_q;
    logic [WW-1:0] w_q;

    logic advance;
    logic illegal_d;
    logic e_clr;
    logic [CNT_W-1:0] cnt;

    assign advance = ~Stall;

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    assign illegal_d = ValidD & ~op_legal(OpD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (advance && !FlushE && illegal_d) begin
            illegal_q <= 1'b1;
        end
    end

    assign IllegalOp = illegal_q;
`else
    logic unused_op;

    assign unused_op = ^OpD;
    assign illegal_d = 1'b0;
    assign IllegalOp = 1'b0;
`endif

    // Decoder outputs are only looked at for a real instruction, so
    // unknown values from an idle decoder never reach Execute.
    always_comb begin
        d_ctrl = CTRL_E_BUBBLE;
        if (ValidD) begin
            d_ctrl.valid       = 1'b1;
            d_ctrl.reg_write   = RegWriteD;
            d_ctrl.result_src  = ResultSrcD;
            d_ctrl.mem_write   = MemWriteD;
            d_ctrl.jump        = JumpD;
            d_ctrl.branch      = BranchD;
            d_ctrl.alu_src     = ALUSrcD;
            d_ctrl.alu_control = ALUControlD;
        end
    end

    assign e_clr = FlushE | ~ValidD | illegal_d;

    ctrl_stage_reg #(.W(EW)) u_reg_e (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (advance),
        .clr   (e_clr),
        .d     (d_ctrl),
        .q     (e_q)
    );

    assign e_ctrl = ctrl_e_t'(e_q);

    always_comb begin
        m_next            = CTRL_M_BUBBLE;
        m_next.valid      = e_ctrl.valid;
        m_next.reg_write  = e_ctrl.reg_write;
        m_next.result_src = e_ctrl.result_src;
        m_next.mem_write  = e_ctrl.mem_write;
    end

    ctrl_stage_reg #(.W(MW)) u_reg_m (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (advance),
        .clr   (1'b0),
        .d     (m_next),
        .q     (m_q)
    );

    assign m_ctrl = ctrl_m_t'(m_q);

    always_comb begin
        w_next            = CTRL_W_BUBBLE;
        w_next.valid      = m_ctrl.valid;
        w_next.reg_write  = m_ctrl.reg_write;
        w_next.result_src = m_ctrl.result_src;
    end

    ctrl_stage_reg #(.W(WW)) u_reg_w (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (advance),
        .clr   (1'b0),
        .d     (w_next),
        .q     (w_q)
    );

    assign w_ctrl = ctrl_w_t'(w_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (advance && w_ctrl.valid) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ALUControlE = e_ctrl.alu_control;
    assign ALUSrcE     = e_ctrl.alu_src;
    assign ResultSrcE0 = e_ctrl.result_src[0];
    assign RegWriteE   = e_ctrl.reg_write;
    assign PCSrcE      = (e_ctrl.branch & ZeroE) | e_ctrl.jump;
    assign RegWriteM   = m_ctrl.reg_write;
    assign MemWriteM   = m_ctrl.mem_write;
    assign RegWriteW   = w_ctrl.reg_write;
    assign ResultSrcW  = w_ctrl.result_src;
    assign RetiredCnt  = cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed testbench for ctrl_pipeline (4-bit retire counter instance).
// Expectations follow ILLEGAL_OP_TRAP_EN when it is defined.
module tb_ctrl_pipeline;
    import riscv_ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          ValidD;
    logic [6:0]    OpD;
    logic          RegWriteD;
    logic [1:0]    ResultSrcD;
    logic          MemWriteD;
    logic          JumpD;
    logic          BranchD;
    logic          ALUSrcD;
    logic [2:0]    ALUControlD;
    logic          FlushE;
    logic          Stall;
    logic          ZeroE;
    logic [2:0]    ALUControlE;
    logic          ALUSrcE;
    logic          ResultSrcE0;
    logic          RegWriteE;
    logic          PCSrcE;
    logic          RegWriteM;
    logic          MemWriteM;
    logic          RegWriteW;
    logic [1:0]    ResultSrcW;
    logic [CW-1:0] RetiredCnt;
    logic          IllegalOp;

    int tests;
    int fails;

    ctrl_pipeline #(.ALUCTRL_W(3), .RSRC_W(2), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ValidD      (ValidD),
        .OpD         (OpD),
        .RegWriteD   (RegWriteD),
        .ResultSrcD  (ResultSrcD),
        .MemWriteD   (MemWriteD),
        .JumpD       (JumpD),
        .BranchD     (BranchD),
        .ALUSrcD     (ALUSrcD),
        .ALUControlD (ALUControlD),
        .FlushE      (FlushE),
        .Stall       (Stall),
        .ZeroE       (ZeroE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE0 (ResultSrcE0),
        .RegWriteE   (RegWriteE),
        .PCSrcE      (PCSrcE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RetiredCnt  (RetiredCnt),
        .IllegalOp   (IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [6:0] op, input logic rw,
                         input logic [1:0] rs, input logic mw,
                         input logic j, input logic b,
                         input logic as, input logic [2:0] alu);
        ValidD      = 1'b1;
        OpD         = op;
        RegWriteD   = rw;
        ResultSrcD  = rs;
        MemWriteD   = mw;
        JumpD       = j;
        BranchD     = b;
        ALUSrcD     = as;
        ALUControlD = alu;
    endtask

    // Idle decoder: outputs driven unknown on purpose.
    task automatic clr_d();
        ValidD      = 1'b0;
        OpD         = 'x;
        RegWriteD   = 'x;
        ResultSrcD  = 'x;
        MemWriteD   = 'x;
        JumpD       = 'x;
        BranchD     = 'x;
        ALUSrcD     = 'x;
        ALUControlD = 'x;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        Stall   = 1'b0;
        FlushE  = 1'b0;
        ZeroE   = 1'b1;
        clr_d();
        tick();
        tick();
        tests++; if (ALUControlE !== 3'b000) begin fails++; $display("FAIL rst_aluctrl_e: got %b want 000", ALUControlE); end
        tests++; if (ALUSrcE !== 1'b0) begin fails++; $display("FAIL rst_alusrc_e: got %b want 0", ALUSrcE); end
        tests++; if (ResultSrcE0 !== 1'b0) begin fails++; $display("FAIL rst_ressrc_e0: got %b want 0", ResultSrcE0); end
        tests++; if (RegWriteE !== 1'b0) begin fails++; $display("FAIL rst_regwrite_e: got %b want 0", RegWriteE); end
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL rst_pcsrc_e: got %b want 0", PCSrcE); end
        tests++; if (RegWriteM !== 1'b0) begin fails++; $display("FAIL rst_regwrite_m: got %b want 0", RegWriteM); end
        tests++; if (MemWriteM !== 1'b0) begin fails++; $display("FAIL rst_memwrite_m: got %b want 0", MemWriteM); end
        tests++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL rst_regwrite_w: got %b want 0", RegWriteW); end
        tests++; if (ResultSrcW !== 2'b00) begin fails++; $display("FAIL rst_ressrc_w: got %b want 00", ResultSrcW); end
        tests++; if (RetiredCnt !== 4'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", RetiredCnt); end
        tests++; if (IllegalOp !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %b want 0", IllegalOp); end
        reset_n = 1'b1;
        ZeroE   = 1'b0;
        tick();
        tests++; if (RegWriteE !== 1'b0) begin fails++; $display("FAIL idle_regwrite_e: got %b want 0", RegWriteE); end
    endtask

    task automatic test_lw();
        set_d(OP_LW, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        clr_d();
        tests++; if (ResultSrcE0 !== 1'b1) begin fails++; $display("FAIL lw_ressrc_e0: got %b want 1", ResultSrcE0); end
        tests++; if (RegWriteE !== 1'b1) begin fails++; $display("FAIL lw_regwrite_e: got %b want 1", RegWriteE); end
        tests++; if (ALUSrcE !== 1'b1) begin fails++; $display("FAIL lw_alusrc_e: got %b want 1", ALUSrcE); end
        tests++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL lw_early_w1: got %b want 0", RegWriteW); end
        tick();
        tests++; if (RegWriteM !== 1'b1) begin fails++; $display("FAIL lw_regwrite_m: got %b want 1", RegWriteM); end
        tests++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL lw_early_w2: got %b want 0", RegWriteW); end
        tick();
        tests++; if (RegWriteW !== 1'b1) begin fails++; $display("FAIL lw_regwrite_w: got %b want 1", RegWriteW); end
        tests++; if (ResultSrcW !== 2'b01) begin fails++; $display("FAIL lw_ressrc_w: got %b want 01", ResultSrcW); end
        tests++; if (RetiredCnt !== 4'd0) begin fails++; $display("FAIL lw_cnt_pre: got %0d want 0", RetiredCnt); end
        tick();
        tests++; if (RetiredCnt !== 4'd1) begin fails++; $display("FAIL lw_cnt: got %0d want 1", RetiredCnt); end
        tests++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL lw_w_drain: got %b want 0", RegWriteW); end
    endtask

    task automatic test_flush();
        set_d(OP_SW, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        clr_d();
        tests++; if (ALUSrcE !== 1'b0) begin fails++; $display("FAIL flush_alusrc_e: got %b want 0", ALUSrcE); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (MemWriteM !== 1'b0) begin fails++; $display("FAIL flush_memwrite_m%0d: got %b want 0", i, MemWriteM); end
            tick();
        end
        tests++; if (RetiredCnt !== 4'd1) begin fails++; $display("FAIL flush_cnt: got %0d want 1", RetiredCnt); end
        set_d(OP_SW, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        clr_d();
        tick();
        tests++; if (MemWriteM !== 1'b1) begin fails++; $display("FAIL sw_memwrite_m: got %b want 1", MemWriteM); end
        tests++; if (RegWriteM !== 1'b0) begin fails++; $display("FAIL sw_regwrite_m: got %b want 0", RegWriteM); end
        tick();
        tick();
        tests++; if (RetiredCnt !== 4'd2) begin fails++; $display("FAIL sw_cnt: got %0d want 2", RetiredCnt); end
    endtask

    task automatic test_pcsrc();
        set_d(OP_BEQ, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
        tick();
        set_d(OP_JAL, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        ZeroE = 1'b1;
        #1;
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL beq_taken: got %b want 1", PCSrcE); end
        tests++; if (ALUControlE !== 3'b001) begin fails++; $display("FAIL beq_aluctrl: got %b want 001", ALUControlE); end
        ZeroE = 1'b0;
        #1;
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL beq_not_taken: got %b want 0", PCSrcE); end
        tick();
        clr_d();
        #1;
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL jal_pcsrc: got %b want 1", PCSrcE); end
        tick();
        ZeroE = 1'b1;
        #1;
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL bubble_pcsrc: got %b want 0", PCSrcE); end
        ZeroE = 1'b0;
        tick();
        tests++; if (ResultSrcW !== 2'b10) begin fails++; $display("FAIL jal_ressrc_w: got %b want 10", ResultSrcW); end
        tick();
        tick();
        tests++; if (RetiredCnt !== 4'd4) begin fails++; $display("FAIL pcsrc_cnt: got %0d want 4", RetiredCnt); end
    endtask

    task automatic test_stall();
        set_d(OP_R, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
        tick();
        set_d(OP_I, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        set_d(OP_SW, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011);
        Stall  = 1'b1;
        FlushE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (RegWriteE !== 1'b1 || ALUSrcE !== 1'b1 || ALUControlE !== 3'b000) begin
                fails++; $display("FAIL stall_e%0d: got rw=%b as=%b alu=%b want 1 1 000", i, RegWriteE, ALUSrcE, ALUControlE); end
            tests++; if (RegWriteM !== 1'b1 || MemWriteM !== 1'b0) begin
                fails++; $display("FAIL stall_m%0d: got rw=%b mw=%b want 1 0", i, RegWriteM, MemWriteM); end
            tests++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL stall_w%0d: got %b want 0", i, RegWriteW); end
            tests++; if (RetiredCnt !== 4'd4) begin fails++; $display("FAIL stall_cnt%0d: got %0d want 4", i, RetiredCnt); end
        end
        Stall  = 1'b0;
        FlushE = 1'b0;
        clr_d();
        tick();
        tests++; if (RegWriteW !== 1'b1) begin fails++; $display("FAIL release_w: got %b want 1", RegWriteW); end
        tests++; if (RegWriteM !== 1'b1) begin fails++; $display("FAIL release_m: got %b want 1", RegWriteM); end
        tests++; if (RegWriteE !== 1'b0) begin fails++; $display("FAIL release_e: got %b want 0", RegWriteE); end
        tests++; if (RetiredCnt !== 4'd4) begin fails++; $display("FAIL release_cnt0: got %0d want 4", RetiredCnt); end
        tick();
        tests++; if (RetiredCnt !== 4'd5) begin fails++; $display("FAIL release_cnt1: got %0d want 5", RetiredCnt); end
        tick();
        tests++; if (RetiredCnt !== 4'd6) begin fails++; $display("FAIL release_cnt2: got %0d want 6", RetiredCnt); end
    endtask

    task automatic test_async_reset();
        set_d(OP_R, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
        tick();
        tick();
        set_d(OP_JAL, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        tests++; if (PCSrcE !== 1'b1 || RegWriteW !== 1'b1) begin
            fails++; $display("FAIL prereset_state: got pc=%b rww=%b want 1 1", PCSrcE, RegWriteW); end
        #3;
        reset_n = 1'b0;
        #1;
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL async_pcsrc: got %b want 0", PCSrcE); end
        tests++; if (RegWriteE !== 1'b0 || RegWriteM !== 1'b0 || RegWriteW !== 1'b0) begin
            fails++; $display("FAIL async_regwrite: got e=%b m=%b w=%b want 0 0 0", RegWriteE, RegWriteM, RegWriteW); end
        tests++; if (ResultSrcW !== 2'b00 || ALUControlE !== 3'b000) begin
            fails++; $display("FAIL async_fields: got rs=%b alu=%b want 00 000", ResultSrcW, ALUControlE); end
        tests++; if (RetiredCnt !== 4'd0) begin fails++; $display("FAIL async_cnt: got %0d want 0", RetiredCnt); end
        clr_d();
        #2;
        reset_n = 1'b1;
        tick();
        tests++; if (RegWriteE !== 1'b0 || RegWriteW !== 1'b0 || RetiredCnt !== 4'd0) begin
            fails++; $display("FAIL post_reset: got e=%b w=%b cnt=%0d want 0 0 0", RegWriteE, RegWriteW, RetiredCnt); end
    endtask

    task automatic test_wrap();
        set_d(OP_R, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
        for (int k = 1; k <= 20; k++) begin
            if (k == 17) clr_d();
            tick();
            if (k == 18) begin
                tests++; if (RetiredCnt !== 4'd15) begin fails++; $display("FAIL wrap_cnt15: got %0d want 15", RetiredCnt); end
            end
            if (k == 19) begin
                tests++; if (RetiredCnt !== 4'd0) begin fails++; $display("FAIL wrap_cnt0: got %0d want 0", RetiredCnt); end
            end
        end
        tests++; if (RetiredCnt !== 4'd0) begin fails++; $display("FAIL wrap_settle: got %0d want 0", RetiredCnt); end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_OP_TRAP_EN
        set_d(7'b0110111, 1'bx, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        clr_d();
        tests++; if (RegWriteE !== 1'b0) begin fails++; $display("FAIL illegal_regwrite_e: got %b want 0", RegWriteE); end
        tests++; if (IllegalOp !== 1'b1) begin fails++; $display("FAIL illegal_set: got %b want 1", IllegalOp); end
        set_d(OP_R, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
        tick();
        clr_d();
        tests++; if (RegWriteE !== 1'b1) begin fails++; $display("FAIL illegal_next_legal: got %b want 1", RegWriteE); end
        repeat (3) tick();
        tests++; if (IllegalOp !== 1'b1) begin fails++; $display("FAIL illegal_sticky: got %b want 1", IllegalOp); end
        tests++; if (RetiredCnt !== 4'd1) begin fails++; $display("FAIL illegal_cnt: got %0d want 1", RetiredCnt); end
`else
        set_d(7'b0110111, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        clr_d();
        tests++; if (RegWriteE !== 1'b1) begin fails++; $display("FAIL lui_regwrite_e: got %b want 1", RegWriteE); end
        tests++; if (IllegalOp !== 1'b0) begin fails++; $display("FAIL lui_illegal: got %b want 0", IllegalOp); end
        repeat (3) tick();
        tests++; if (IllegalOp !== 1'b0) begin fails++; $display("FAIL lui_illegal_late: got %b want 0", IllegalOp); end
        tests++; if (RetiredCnt !== 4'd1) begin fails++; $display("FAIL lui_cnt: got %0d want 1", RetiredCnt); end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_lw();
        test_flush();
        test_pcsrc();
        test_stall();
        test_async_reset();
        test_wrap();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
